// File: rtl/vscpu_mem_pkg.sv
// Shared types and defaults for the instruction/data RAM port arbiter.
// ARB_ROUND_ROBIN_EN (see ram_port_arbiter) selects the contention policy.
package vscpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int PORT_CPU   = 0;
  localparam int PORT_HOST  = 1;

  localparam int SIZE_DEF   = 14;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way pick: a lone requester always wins; on contention
// either port 0 wins (fixed_mode) or the port selected by prio_ptr wins.
module arb_pick2 (
  input  logic [1:0] req,
  input  logic       prio_ptr,
  input  logic       fixed_mode,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      if (fixed_mode || !prio_ptr) gnt = 2'b01;
      else                         gnt = 2'b10;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port instruction/data RAM between CPU (port 0) and host (port 1).
// Build option ARB_ROUND_ROBIN_EN: round-robin contention instead of fixed port-0 priority.
//
// state | meaning
// IDLE  | arbitrate among requesters every cycle
// OWN0  | port 0 holds the lock; only port 0 may be granted
// OWN1  | port 1 holds the lock; only port 1 may be granted
module ram_port_arbiter
  import vscpu_mem_pkg::*;
#(
  parameter int SIZE     = SIZE_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [SIZE-1:0]   addr0,
  input  logic [SIZE-1:0]   addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              wrEn,
  output logic [SIZE-1:0]   addr_toRAM,
  output logic [DATA_W-1:0] data_toRAM,
  input  logic [DATA_W-1:0] data_fromRAM
);

  localparam int                CNT_W    = $clog2(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic [1:0]       pick;
  logic             fixed_mode;

`ifdef ARB_ROUND_ROBIN_EN
  assign fixed_mode = 1'b0;
`else
  // Set for the single IDLE cycle after a forced release so the pointer decides.
  logic ovr_q, ovr_d;
  assign fixed_mode = ~ovr_q;
`endif

  arb_pick2 u_pick (
    .req        ({req1, req0}),
    .prio_ptr   (ptr_q),
    .fixed_mode (fixed_mode),
    .gnt        (pick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
    ovr_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        gnt0 = pick[PORT_CPU];
        gnt1 = pick[PORT_HOST];
`ifdef ARB_ROUND_ROBIN_EN
        if (gnt0)      ptr_d = 1'b1;
        else if (gnt1) ptr_d = 1'b0;
`endif
        if (gnt0 && lock0) begin
          state_d = OWN0;
          cnt_d   = '0;
        end else if (gnt1 && lock1) begin
          state_d = OWN1;
          cnt_d   = '0;
        end
      end
      OWN0, OWN1: begin
        gnt0 = (state_q == OWN0) && req0;
        gnt1 = (state_q == OWN1) && req1;
        if (cnt_q != CNT_LAST) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Watchdog: hand the next contended IDLE cycle to the other port.
          state_d = IDLE;
          ptr_d   = (state_q == OWN0);
`ifndef ARB_ROUND_ROBIN_EN
          ovr_d   = 1'b1;
`endif
        end else if (state_q == OWN0 ? (!req0 || !lock0) : (!req1 || !lock1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wrEn       = 1'b0;
    addr_toRAM = '0;
    data_toRAM = '0;
    if (gnt0) begin
      wrEn       = wr0;
      addr_toRAM = addr0;
      data_toRAM = wdata0;
    end else if (gnt1) begin
      wrEn       = wr1;
      addr_toRAM = addr1;
      data_toRAM = wdata1;
    end
  end

  assign rvalid0_d = gnt0 & ~wr0;
  assign rvalid1_d = gnt1 & ~wr1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
      ovr_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
`ifndef ARB_ROUND_ROBIN_EN
      ovr_q     <= ovr_d;
`endif
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = data_fromRAM;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios then random traffic,
// compared against a transaction-level ownership model and a shadow memory.
module tb_ram_port_arbiter;

  localparam int SIZE     = 14;
  localparam int DATA_W   = 32;
  localparam int LOCK_MAX = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [SIZE-1:0]   addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1, wrEn;
  logic [DATA_W-1:0] rdata, data_toRAM;
  logic [DATA_W-1:0] data_fromRAM;
  logic [SIZE-1:0]   addr_toRAM;

  ram_port_arbiter #(.SIZE(SIZE), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .wr0(wr0), .wr1(wr1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .wrEn(wrEn), .addr_toRAM(addr_toRAM),
    .data_toRAM(data_toRAM), .data_fromRAM(data_fromRAM)
  );

  always #5 clk = ~clk;

  // Environment RAM driven by the arbiter's RAM-side outputs.
  logic [DATA_W-1:0] ram     [0:(1<<SIZE)-1];
  logic [DATA_W-1:0] ref_mem [0:(1<<SIZE)-1];

  always @(posedge clk) begin
    if (wrEn) ram[addr_toRAM] <= data_toRAM;
    data_fromRAM <= ram[addr_toRAM];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the RAM, how long, who is favoured next.
  int                m_owner    = -1;
  int                m_held     = 0;
  int                m_pref     = 0;
  bit                m_override = 1'b0;
  bit                m_rv0      = 1'b0;
  bit                m_rv1      = 1'b0;
  logic [DATA_W-1:0] m_rdata    = '0;
  int                gnt1_run   = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rs,
                      input logic r0, input logic l0, input logic w0,
                      input logic [SIZE-1:0] a0, input logic [DATA_W-1:0] d0,
                      input logic r1, input logic l1, input logic w1,
                      input logic [SIZE-1:0] a1, input logic [DATA_W-1:0] d1);
    int win;
    bit ew;
    logic [SIZE-1:0]   ea;
    logic [DATA_W-1:0] ed;
    @(negedge clk);
    rst = rs; req0 = r0; lock0 = l0; wr0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; lock1 = l1; wr1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    if (m_owner < 0) begin
      if (r0 && r1)  win = (RR_MODE || m_override) ? m_pref : 0;
      else if (r0)   win = 0;
      else if (r1)   win = 1;
      else           win = -1;
    end else begin
      win = ((m_owner == 0) ? r0 : r1) ? m_owner : -1;
    end
    ew = 1'b0; ea = '0; ed = '0;
    if (win == 0) begin ew = w0; ea = a0; ed = d0; end
    if (win == 1) begin ew = w1; ea = a1; ed = d1; end

    chk("gnt0", 32'(gnt0), 32'(win == 0));
    chk("gnt1", 32'(gnt1), 32'(win == 1));
    chk("wrEn", 32'(wrEn), 32'(ew));
    chk("addr_toRAM", 32'(addr_toRAM), 32'(ea));
    chk("data_toRAM", data_toRAM, ed);
    chk("rvalid0", 32'(rvalid0), 32'(m_rv0));
    chk("rvalid1", 32'(rvalid1), 32'(m_rv1));
    if (m_rv0 || m_rv1) chk("rdata", rdata, m_rdata);

    gnt1_run = (win == 1) ? gnt1_run + 1 : 0;

    // Advance the model to the next cycle.
    m_rv0 = (win == 0) && !w0;
    m_rv1 = (win == 1) && !w1;
    if (win >= 0) begin
      if (ew) ref_mem[ea] = ed;
      else    m_rdata = ref_mem[ea];
    end
    if (rs) begin
      m_owner = -1; m_held = 0; m_pref = 0; m_override = 1'b0;
      m_rv0 = 1'b0; m_rv1 = 1'b0;
    end else if (m_owner < 0) begin
      m_override = 1'b0;
      if (win >= 0) begin
        if (RR_MODE) m_pref = 1 - win;
        if ((win == 0) ? l0 : l1) begin
          m_owner = win;
          m_held  = 0;
        end
      end
    end else if (m_held == LOCK_MAX - 1) begin
      m_pref     = 1 - m_owner;
      m_override = 1'b1;
      m_owner    = -1;
    end else if (!((m_owner == 0) ? (r0 && l0) : (r1 && l1))) begin
      m_owner = -1;
    end else begin
      m_held++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0,0,0,'0,'0, 0,0,0,'0,'0);
  endtask

  initial begin
    for (int i = 0; i < (1 << SIZE); i++) begin
      ram[i]     = 32'(i) * 32'h9E37_79B1;
      ref_mem[i] = 32'(i) * 32'h9E37_79B1;
    end
    ram[5]     = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;

    // Reset, then quiet bus.
    step(1, 0,0,0,'0,'0, 0,0,0,'0,'0);
    step(1, 0,0,0,'0,'0, 0,0,0,'0,'0);
    idle(2);

    // Single read by port 0.
    step(0, 1,0,0,14'h005,'0, 0,0,0,'0,'0);
    idle(1);
    chk("t1_rdata", rdata, 32'hDEAD_BEEF);

    // Contention without locks.
    for (int i = 0; i < 4; i++)
      step(0, 1,0,0,14'(i),'0, 1,0,0,14'(i+8),'0);
    idle(1);

    // Port 1 holds a lock while port 0 waits; watchdog releases it.
    step(0, 0,0,0,'0,'0, 1,1,0,14'h010,'0);
    for (int i = 0; i < LOCK_MAX; i++)
      step(0, 1,0,0,14'h020,'0, 1,1,0,14'(16+i),'0);
    chk("t3_gnt1_run", 32'(gnt1_run), 32'(LOCK_MAX + 1));
    step(0, 1,0,0,14'h020,'0, 1,1,0,14'h011,'0);
    chk("t3_gnt0_after", 32'(gnt0), 32'd1);
    idle(2);

    // Host write, then CPU read-back.
    step(0, 0,0,0,'0,'0, 1,0,1,14'h3FF,32'h1234_5678);
    step(0, 1,0,0,14'h3FF,'0, 0,0,0,'0,'0);
    idle(1);
    chk("t4_readback", rdata, 32'h1234_5678);

    // Reset in the cycle a read is granted.
    step(1, 1,0,0,14'h005,'0, 0,0,0,'0,'0);
    idle(1);
    chk("t5_rvalid0", 32'(rvalid0), 32'd0);

    // Port 0 locks for three accesses, then releases to waiting port 1.
    step(0, 1,1,0,14'h001,'0, 0,0,0,'0,'0);
    step(0, 1,1,0,14'h002,'0, 1,0,0,14'h030,'0);
    step(0, 1,1,0,14'h003,'0, 1,0,0,14'h030,'0);
    step(0, 1,0,0,14'h004,'0, 1,0,0,14'h030,'0);
    step(0, 0,0,0,'0,'0,      1,0,0,14'h030,'0);
    chk("t6_gnt1", 32'(gnt1), 32'd1);
    idle(2);

    // Random traffic over a small address window.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3),
           14'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3),
           14'($urandom_range(0, 15)), $urandom);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
